// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Holds opcode constants, state encodings, ALU/PC select encodings and the
// control-word type exchanged between the state decoder and the top level.
// Optional feature macro: MCU_JUMP_EN. When it is defined, the j instruction
// (opcode 000010) is supported.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control word. gate_rdy marks fields that must also be
    // qualified by mem_ready (pcen, irwe, instr_done); gate_zero marks pcen
    // as conditional on the ALU zero flag.
    typedef struct packed {
        logic       pcen;
        logic       irwe;
        logic       memadrsel;
        logic       dmwe;
        logic       mtorfsel;
        logic       rfdsel;
        logic       rfwe;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       gate_rdy;
        logic       gate_zero;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI);
`ifdef MCU_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_out_decode.sv
// mcu_out_decode: purely combinational map from sequencer state to the raw
// control word. Handshake and flag qualification is applied by the caller.
// Ports:
//   state_i  in  current (reset-adjusted) sequencer state
//   ctrl_o   out raw control word for that state
// Optional feature macro: MCU_JUMP_EN (decodes the JUMP state).
module mcu_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb  = SRCB_FOUR;
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.pcsrc    = PCSRC_ALU;
                ctrl_o.pcen     = 1'b1;
                ctrl_o.irwe     = 1'b1;
                ctrl_o.gate_rdy = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                ctrl_o.alusrcb = SRCB_IMMSH2;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memadrsel = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mtorfsel   = 1'b1;
                ctrl_o.rfwe       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memadrsel  = 1'b1;
                ctrl_o.dmwe       = 1'b1;
                ctrl_o.instr_done = 1'b1;
                ctrl_o.gate_rdy   = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REG;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.rfdsel     = 1'b1;
                ctrl_o.rfwe       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca    = 1'b1;
                ctrl_o.alusrcb    = SRCB_REG;
                ctrl_o.aluop      = ALUOP_SUB;
                ctrl_o.pcsrc      = PCSRC_ALUOUT;
                ctrl_o.pcen       = 1'b1;
                ctrl_o.gate_zero  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.rfwe       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                ctrl_o.pcsrc      = PCSRC_JUMP;
                ctrl_o.pcen       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore sequencer for a multi-cycle MIPS datapath with a
// unified memory and shared ALU. Steps each instruction through fetch,
// decode, execute, memory and writeback, stalling on mem_ready.
// Ports:
//   CLK, RST (sync, active-high)       clock and reset
//   opcode[5:0], Zero, mem_ready       IR opcode, ALU zero flag, memory done
//   PCEn, IRWE, DMWE, RFWE             write enables (forced low in reset)
//   MemAdrSel, MtoRFSel, RFDSel        datapath mux selects
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]  ALU operand/operation selects
//   PCSrc[1:0]                         next-PC select
//   instr_done, illegal                instruction-end and bad-opcode flags
// Optional feature macro: MCU_JUMP_EN (enables j / JUMP state).
module multi_cycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IRWE,
    output logic       MemAdrSel,
    output logic       DMWE,
    output logic       MtoRFSel,
    output logic       RFDSel,
    output logic       RFWE,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal
);

    state_t state_q, state_d;
    state_t dec_state;
    ctrl_t  cw;
    logic   rdy_ok, zero_ok, bad_op;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MCU_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // During reset the selects show FETCH values; the enables are masked below.
    assign dec_state = RST ? S_FETCH : state_q;

    mcu_out_decode u_dec (
        .state_i (dec_state),
        .ctrl_o  (cw)
    );

    assign rdy_ok  = ~cw.gate_rdy  | mem_ready;
    assign zero_ok = ~cw.gate_zero | Zero;
    assign bad_op  = (dec_state == S_DECODE) && !op_supported(opcode);

    assign PCEn       = cw.pcen & rdy_ok & zero_ok & ~RST;
    assign IRWE       = cw.irwe & rdy_ok & ~RST;
    assign DMWE       = cw.dmwe & ~RST;
    assign RFWE       = cw.rfwe & ~RST;
    assign MemAdrSel  = cw.memadrsel;
    assign MtoRFSel   = cw.mtorfsel;
    assign RFDSel     = cw.rfdsel;
    assign ALUSrcA    = cw.alusrca;
    assign ALUSrcB    = cw.alusrcb;
    assign ALUOp      = cw.aluop;
    assign PCSrc      = cw.pcsrc;
    assign instr_done = (cw.instr_done & rdy_ok) | bad_op;
    assign illegal    = bad_op;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCEn, IRWE, MemAdrSel, DMWE, MtoRFSel, RFDSel, RFWE, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, illegal;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] sb_q[$];
    string       tag_q[$];

    always #5 CLK = ~CLK;

    multi_cycle_ctrl dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCEn(PCEn), .IRWE(IRWE), .MemAdrSel(MemAdrSel), .DMWE(DMWE),
        .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .RFWE(RFWE), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .instr_done(instr_done), .illegal(illegal)
    );

    // Packing: {PCEn,IRWE,MemAdrSel,DMWE,MtoRFSel,RFDSel,RFWE,ALUSrcA,
    //           ALUSrcB,ALUOp,PCSrc,instr_done,illegal}
    function automatic logic [15:0] cv(input logic pcen, irwe, mas, dmwe, m2r, rfd, rfwe, srca,
                                       input logic [1:0] srcb, aluop, pcsrc,
                                       input logic done, ill);
        return {pcen, irwe, mas, dmwe, m2r, rfd, rfwe, srca, srcb, aluop, pcsrc, done, ill};
    endfunction

    function automatic logic [15:0] e_fetch(input logic rdy);
        return cv(rdy, rdy, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_decode(input logic ill);
        return cv(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill, ill);
    endfunction
    function automatic logic [15:0] e_memadr();
        return cv(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_memrd();
        return cv(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_memwb();
        return cv(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic logic [15:0] e_memwr(input logic rdy);
        return cv(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, rdy, 0);
    endfunction
    function automatic logic [15:0] e_exec();
        return cv(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_aluwb();
        return cv(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic logic [15:0] e_branch(input logic z);
        return cv(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    endfunction
    function automatic logic [15:0] e_addiwb();
        return cv(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic logic [15:0] e_jump();
        return cv(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    endfunction

    // One clock cycle: drive inputs at the falling edge, queue the expected
    // control word, then compare it against the settled outputs.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic z, input logic rdy, input logic [15:0] exp);
        logic [15:0] obs, want;
        string       t;
        @(negedge CLK);
        RST = rst; opcode = op; Zero = z; mem_ready = rdy;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        obs = {PCEn, IRWE, MemAdrSel, DMWE, MtoRFSel, RFDSel, RFWE, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, instr_done, illegal};
        want = sb_q.pop_front();
        t = tag_q.pop_front();
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset for two cycles with mem_ready high: enables must stay masked
        cyc("rst0", 1, 6'b100011, 0, 1, e_fetch(0));
        cyc("rst1", 1, 6'b100011, 0, 1, e_fetch(0));

        // lw, no stalls: 5 cycles
        cyc("lw_fetch",  0, 6'b100011, 0, 1, e_fetch(1));
        cyc("lw_decode", 0, 6'b100011, 0, 1, e_decode(0));
        cyc("lw_memadr", 0, 6'b100011, 0, 1, e_memadr());
        cyc("lw_memrd",  0, 6'b100011, 0, 1, e_memrd());
        cyc("lw_memwb",  0, 6'b100011, 0, 1, e_memwb());

        // sw with 3 stall cycles in MEMWR
        cyc("sw_fetch",  0, 6'b101011, 0, 1, e_fetch(1));
        cyc("sw_decode", 0, 6'b101011, 0, 1, e_decode(0));
        cyc("sw_memadr", 0, 6'b101011, 0, 1, e_memadr());
        cyc("sw_wait0",  0, 6'b101011, 0, 0, e_memwr(0));
        cyc("sw_wait1",  0, 6'b101011, 0, 0, e_memwr(0));
        cyc("sw_wait2",  0, 6'b101011, 0, 0, e_memwr(0));
        cyc("sw_memwr",  0, 6'b101011, 0, 1, e_memwr(1));

        // beq taken then not taken
        cyc("beq1_fetch",  0, 6'b000100, 1, 1, e_fetch(1));
        cyc("beq1_decode", 0, 6'b000100, 1, 1, e_decode(0));
        cyc("beq1_branch", 0, 6'b000100, 1, 1, e_branch(1));
        cyc("beq0_fetch",  0, 6'b000100, 0, 1, e_fetch(1));
        cyc("beq0_decode", 0, 6'b000100, 0, 1, e_decode(0));
        cyc("beq0_branch", 0, 6'b000100, 0, 1, e_branch(0));

        // unrecognised opcode
        cyc("ill_fetch",  0, 6'b111111, 0, 1, e_fetch(1));
        cyc("ill_decode", 0, 6'b111111, 0, 1, e_decode(1));

        // jump
        cyc("j_fetch",  0, 6'b000010, 0, 1, e_fetch(1));
`ifdef MCU_JUMP_EN
        cyc("j_decode", 0, 6'b000010, 0, 1, e_decode(0));
        cyc("j_jump",   0, 6'b000010, 0, 1, e_jump());
`else
        cyc("j_decode_ill", 0, 6'b000010, 0, 1, e_decode(1));
`endif

        // addi
        cyc("addi_fetch",  0, 6'b001000, 0, 1, e_fetch(1));
        cyc("addi_decode", 0, 6'b001000, 0, 1, e_decode(0));
        cyc("addi_ex",     0, 6'b001000, 0, 1, e_memadr());
        cyc("addi_wb",     0, 6'b001000, 0, 1, e_addiwb());

        // R-type, full run, with a fetch stall
        cyc("r_fetch_stall0", 0, 6'b000000, 0, 0, e_fetch(0));
        cyc("r_fetch_stall1", 0, 6'b000000, 0, 0, e_fetch(0));
        cyc("r_fetch",        0, 6'b000000, 0, 1, e_fetch(1));
        cyc("r_decode",       0, 6'b000000, 0, 1, e_decode(0));
        cyc("r_exec",         0, 6'b000000, 0, 1, e_exec());
        cyc("r_aluwb",        0, 6'b000000, 0, 1, e_aluwb());

        // R-type aborted by reset in EXEC: no ALUWB afterwards
        cyc("rab_fetch",  0, 6'b000000, 0, 1, e_fetch(1));
        cyc("rab_decode", 0, 6'b000000, 0, 1, e_decode(0));
        cyc("rab_rst",    1, 6'b000000, 0, 1, e_fetch(0));
        cyc("rab_after",  0, 6'b000000, 0, 1, e_fetch(1));

        // lw with a stall in MEMRD
        cyc("lws_decode", 0, 6'b100011, 0, 1, e_decode(0));
        cyc("lws_memadr", 0, 6'b100011, 0, 1, e_memadr());
        cyc("lws_wait",   0, 6'b100011, 0, 0, e_memrd());
        cyc("lws_memrd",  0, 6'b100011, 0, 1, e_memrd());
        cyc("lws_memwb",  0, 6'b100011, 0, 1, e_memwb());
        cyc("lws_next",   0, 6'b100011, 0, 1, e_fetch(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
